// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Initiator-side controller between the MEM pipeline stage and a word-wide
// DataMemory. Accepts one load/store at a time, drives the memory strobes,
// returns sign/zero-extended load data, performs sub-word stores (SH/SB) as a
// read-modify-write, and rejects misaligned accesses.
//
// Ports:
//   Clk           in   system clock, rising-edge active
//   Reset         in   synchronous, active-high reset
//   Req           in   request strobe, sampled only while Busy=0
//   Op[2:0]       in   000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU,
//                      101 SW, 110 SH, 111 SB
//   Addr          in   byte address of the request
//   StoreData     in   store value (low 16/8 bits used for SH/SB)
//   Busy          out  high while a request is in progress
//   Done          out  one-cycle completion pulse
//   LoadData      out  extended load result, held until the next load
//   Misaligned    out  valid with Done; high means the access was rejected
//   MemAddress    out  word-aligned address to DataMemory
//   MemWriteData  out  write word to DataMemory
//   MemWrite      out  DataMemory write enable
//   MemRead       out  DataMemory read enable
//   MemReadData   in   DataMemory read word (combinational while MemRead=1)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req,
    input  logic [2:0]            Op,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [31:0]           StoreData,
    output logic                  Busy,
    output logic                  Done,
    output logic [31:0]           LoadData,
    output logic                  Misaligned,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [31:0]           MemWriteData,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [31:0]           MemReadData
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR
    } stateType;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } opType;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Words need offset 0, halfwords need an even offset, bytes go anywhere.
    function automatic logic isMisaligned(input opType op, input logic [1:0] offset);
        logic result;
        case (op)
            OP_LW, OP_SW:         result = (offset != 2'b00);
            OP_LH, OP_LHU, OP_SH: result = offset[0];
            default:              result = 1'b0;
        endcase
        return result;
    endfunction

    // Select the addressed lane of a little-endian word and extend it.
    function automatic logic [31:0] extendLoad(input opType op,
                                               input logic [1:0] offset,
                                               input logic [31:0] word);
        logic [7:0]  byteLane;
        logic [15:0] halfLane;
        logic [31:0] result;
        case (offset)
            2'd0:    byteLane = word[7:0];
            2'd1:    byteLane = word[15:8];
            2'd2:    byteLane = word[23:16];
            default: byteLane = word[31:24];
        endcase
        halfLane = offset[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   result = {{24{byteLane[7]}}, byteLane};
            OP_LBU:  result = {24'h000000, byteLane};
            OP_LH:   result = {{16{halfLane[15]}}, halfLane};
            OP_LHU:  result = {16'h0000, halfLane};
            default: result = word;
        endcase
        return result;
    endfunction

    // Replace the addressed byte/halfword of the word read back from memory,
    // preserving every other lane.
    function automatic logic [31:0] mergeStore(input opType op,
                                               input logic [1:0] offset,
                                               input logic [31:0] word,
                                               input logic [31:0] data);
        logic [31:0] result;
        result = word;
        if (op == OP_SB) begin
            case (offset)
                2'd0:    result[7:0]   = data[7:0];
                2'd1:    result[15:8]  = data[7:0];
                2'd2:    result[23:16] = data[7:0];
                default: result[31:24] = data[7:0];
            endcase
        end else if (offset[1]) begin
            result[31:16] = data[15:0];
        end else begin
            result[15:0] = data[15:0];
        end
        return result;
    endfunction

    // -------------------------------------------------------------------------
    // State and latched request
    // -------------------------------------------------------------------------
    stateType    state;
    stateType    nextState;

    opType       opReg;
    logic [1:0]  offsetReg;
    logic [31:0] storeReg;

    opType       nextOp;
    logic [1:0]  nextOffset;
    logic [31:0] nextStore;

    logic                  nextDone;
    logic                  nextMisaligned;
    logic [31:0]           nextLoadData;
    logic [ADDR_WIDTH-1:0] nextMemAddress;
    logic [31:0]           nextMemWriteData;
    logic                  nextMemWrite;
    logic                  nextMemRead;

    // Decode of the incoming request; only meaningful in IDLE with Req=1.
    opType                 reqOp;
    logic                  reqMisaligned;
    logic [ADDR_WIDTH-1:0] reqWordAddr;

    assign reqOp         = opType'(Op);
    assign reqMisaligned = isMisaligned(reqOp, Addr[1:0]);
    assign reqWordAddr   = {Addr[ADDR_WIDTH-1:2], 2'b00};

    assign Busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        // NOTE: sequential state is assigned with non-blocking (<=) so every
        // register samples the pre-edge value of every other register.
        if (Reset) begin
            state        <= IDLE;
            opReg        <= OP_LW;
            offsetReg    <= 2'b00;
            storeReg     <= 32'h0;
            Done         <= 1'b0;
            Misaligned   <= 1'b0;
            LoadData     <= 32'h0;
            MemAddress   <= '0;
            MemWriteData <= 32'h0;
            MemWrite     <= 1'b0;
            MemRead      <= 1'b0;
        end else begin
            state        <= nextState;
            opReg        <= nextOp;
            offsetReg    <= nextOffset;
            storeReg     <= nextStore;
            Done         <= nextDone;
            Misaligned   <= nextMisaligned;
            LoadData     <= nextLoadData;
            MemAddress   <= nextMemAddress;
            MemWriteData <= nextMemWriteData;
            MemWrite     <= nextMemWrite;
            MemRead      <= nextMemRead;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default before the case so no
        // path leaves it unassigned, which would infer a latch.
        nextState        = state;
        nextOp           = opReg;
        nextOffset       = offsetReg;
        nextStore        = storeReg;
        nextDone         = 1'b0;
        nextMisaligned   = 1'b0;
        nextLoadData     = LoadData;
        nextMemAddress   = MemAddress;
        nextMemWriteData = MemWriteData;
        nextMemWrite     = 1'b0;
        nextMemRead      = 1'b0;

        case (state)
            IDLE: begin
                if (Req) begin
                    nextOp         = reqOp;
                    nextOffset     = Addr[1:0];
                    nextStore      = StoreData;
                    nextMemAddress = reqWordAddr;
                    if (reqMisaligned) begin
                        // Rejected without touching memory; report next cycle.
                        nextDone       = 1'b1;
                        nextMisaligned = 1'b1;
                    end else begin
                        case (reqOp)
                            OP_SW: begin
                                nextState        = STORE;
                                nextMemWrite     = 1'b1;
                                nextMemWriteData = StoreData;
                            end
                            OP_SH, OP_SB: begin
                                // Sub-word store: fetch the word first.
                                nextState   = RMW_RD;
                                nextMemRead = 1'b1;
                            end
                            default: begin
                                nextState   = LOAD;
                                nextMemRead = 1'b1;
                            end
                        endcase
                    end
                end
            end

            LOAD: begin
                nextLoadData = extendLoad(opReg, offsetReg, MemReadData);
                nextDone     = 1'b1;
                nextState    = IDLE;
            end

            STORE: begin
                nextDone  = 1'b1;
                nextState = IDLE;
            end

            RMW_RD: begin
                nextMemWriteData = mergeStore(opReg, offsetReg, MemReadData, storeReg);
                nextMemWrite     = 1'b1;
                nextState        = RMW_WR;
            end

            RMW_WR: begin
                nextDone  = 1'b1;
                nextState = IDLE;
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. A simple DataMemory sits on the
// memory port; a reference model (word array + last load value) predicts
// load results, stored words, latency and misalignment from the access rules.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int AW = 32;

    localparam logic [2:0] LW  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LHU = 3'd2;
    localparam logic [2:0] LB  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] SW  = 3'd5;
    localparam logic [2:0] SH  = 3'd6;
    localparam logic [2:0] SB  = 3'd7;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Req;
    logic [2:0]    Op;
    logic [AW-1:0] Addr;
    logic [31:0]   StoreData;
    logic          Busy;
    logic          Done;
    logic [31:0]   LoadData;
    logic          Misaligned;
    logic [AW-1:0] MemAddress;
    logic [31:0]   MemWriteData;
    logic          MemWrite;
    logic          MemRead;
    logic [31:0]   MemReadData;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req         (Req),
        .Op          (Op),
        .Addr        (Addr),
        .StoreData   (StoreData),
        .Busy        (Busy),
        .Done        (Done),
        .LoadData    (LoadData),
        .Misaligned  (Misaligned),
        .MemAddress  (MemAddress),
        .MemWriteData(MemWriteData),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .MemReadData (MemReadData)
    );

    // ---------------------------------------------------------------------
    // DataMemory environment (64 words) and bus monitor
    // ---------------------------------------------------------------------
    logic [31:0] envMem [0:63];
    logic        pokeEn = 1'b0;
    logic [5:0]  pokeIdx = 6'd0;
    logic [31:0] pokeData = 32'h0;
    logic        addrInRange;
    logic        monEn = 1'b0;

    int          writeCount = 0;
    int          readCount = 0;
    int          overlapCount = 0;
    int          strayMisCount = 0;
    logic [31:0] lastWrAddr = 32'h0;
    logic [31:0] lastWrData = 32'h0;

    assign addrInRange = (MemAddress < 32'd256);
    assign MemReadData = (MemRead === 1'b1 && addrInRange) ? envMem[MemAddress[7:2]] : 32'h0;

    always @(posedge Clk) begin
        if (MemWrite === 1'b1) begin
            envMem[MemAddress[7:2]] <= MemWriteData;
            writeCount <= writeCount + 1;
            lastWrAddr <= MemAddress;
            lastWrData <= MemWriteData;
        end else if (pokeEn) begin
            envMem[pokeIdx] <= pokeData;
        end
        if (MemRead === 1'b1)
            readCount <= readCount + 1;
        if (MemRead === 1'b1 && MemWrite === 1'b1)
            overlapCount <= overlapCount + 1;
    end

    always @(negedge Clk) begin
        if (monEn && Misaligned === 1'b1 && Done !== 1'b1)
            strayMisCount <= strayMisCount + 1;
    end

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    logic [31:0] refMem [0:63];
    logic [31:0] refLoad = 32'h0;

    function automatic logic modelMis(input logic [2:0] op, input logic [31:0] addr);
        return ((op == LW || op == SW) && (addr % 4) != 0) ||
               ((op == LH || op == LHU || op == SH) && (addr % 2) != 0);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] v;
        v = refMem[addr[7:2]] >> (8 * (addr % 4));
        if (op == LB || op == LBU) begin
            v = v & 32'h0000_00FF;
            if (op == LB && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (op == LH || op == LHU) begin
            v = v & 32'h0000_FFFF;
            if (op == LH && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic void modelStore(input logic [2:0] op, input logic [31:0] addr,
                                       input logic [31:0] data);
        logic [31:0] mask;
        int          sh;
        sh   = 8 * int'(addr % 4);
        mask = (op == SW) ? 32'hFFFF_FFFF : (op == SH) ? 32'h0000_FFFF : 32'h0000_00FF;
        refMem[addr[7:2]] = (refMem[addr[7:2]] & ~(mask << sh)) | ((data & mask) << sh);
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus helpers (no comparisons here)
    // ---------------------------------------------------------------------
    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge Clk);
        pokeEn   = 1'b1;
        pokeIdx  = idx[5:0];
        pokeData = val;
        @(negedge Clk);
        pokeEn   = 1'b0;
        refMem[idx] = val;
    endtask

    // Issue one request from idle; returns the number of cycles from the Req
    // cycle to the Done cycle (capped at 10) and Misaligned in the Done cycle.
    task automatic doReq(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         output int lat, output logic mis);
        @(negedge Clk);
        Req = 1'b1; Op = op; Addr = addr; StoreData = data;
        @(negedge Clk);
        Req = 1'b0; Op = 3'($urandom_range(0, 7)); Addr = $urandom; StoreData = $urandom;
        lat = 1;
        while (Done !== 1'b1 && lat < 10) begin
            @(negedge Clk);
            lat++;
        end
        mis = Misaligned;
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        Reset = 1'b1;
        for (int i = 0; i < 64; i++) poke(i, $urandom);
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
        checks++; if (Misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", Misaligned); end
        checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b0) begin errors++; $display("FAIL reset_enables: rd %b wr %b want 0 0", MemRead, MemWrite); end
        checks++; if (LoadData !== 32'h0) begin errors++; $display("FAIL reset_loaddata: got %h want 0", LoadData); end
        checks++; if (MemAddress !== 32'h0 || MemWriteData !== 32'h0) begin errors++; $display("FAIL reset_membus: addr %h data %h want 0 0", MemAddress, MemWriteData); end
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b done %b want 0 0", Busy, Done); end
        monEn = 1'b1;
    endtask

    task automatic test_store_load();
        int lat; logic mis; int w0;
        w0 = writeCount;
        doReq(SW, 32'd4, 32'hDEADBEEF, lat, mis);
        modelStore(SW, 32'd4, 32'hDEADBEEF);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
        checks++; if (writeCount - w0 !== 1) begin errors++; $display("FAIL sw_write_cycles: got %0d want 1", writeCount - w0); end
        checks++; if (lastWrAddr !== 32'd4 || lastWrData !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_write: addr %h data %h want 4 deadbeef", lastWrAddr, lastWrData); end
        checks++; if (Busy !== 1'b0 || mis !== 1'b0) begin errors++; $display("FAIL sw_done_cycle: busy %b mis %b want 0 0", Busy, mis); end
        @(negedge Clk);
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", Done); end
        doReq(LW, 32'd4, 32'h0, lat, mis);
        refLoad = 32'hDEADBEEF;
        checks++; if (LoadData !== 32'hDEADBEEF || mis !== 1'b0) begin errors++; $display("FAIL lw_readback: data %h mis %b want deadbeef 0", LoadData, mis); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
    endtask

    task automatic test_subword_loads();
        logic [2:0]  ops  [4];
        logic [31:0] adrs [4];
        logic [31:0] exps [4];
        int lat; logic mis;
        ops  = '{LB, LBU, LH, LHU};
        adrs = '{32'd9, 32'd9, 32'd10, 32'd8};
        exps = '{32'hFFFFFFBA, 32'h000000BA, 32'hFFFFCAFE, 32'h0000BABE};
        poke(2, 32'hCAFEBABE);
        for (int i = 0; i < 4; i++) begin
            doReq(ops[i], adrs[i], $urandom, lat, mis);
            refLoad = exps[i];
            checks++; if (LoadData !== exps[i] || mis !== 1'b0 || lat !== 2) begin
                errors++; $display("FAIL subword_load_%0d: data %h mis %b lat %0d want %h 0 2", i, LoadData, mis, lat, exps[i]);
            end
        end
    endtask

    task automatic test_rmw();
        int lat; logic mis; int w0; int r0;
        poke(2, 32'hCAFEBABE);
        w0 = writeCount; r0 = readCount;
        doReq(SB, 32'd11, 32'h12, lat, mis);
        modelStore(SB, 32'd11, 32'h12);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", lat); end
        checks++; if (readCount - r0 !== 1 || writeCount - w0 !== 1) begin errors++; $display("FAIL sb_cycles: rd %0d wr %0d want 1 1", readCount - r0, writeCount - w0); end
        checks++; if (lastWrData !== 32'h12FEBABE || lastWrAddr !== 32'd8) begin errors++; $display("FAIL sb_merge: addr %h data %h want 8 12febabe", lastWrAddr, lastWrData); end
        doReq(SH, 32'd8, 32'h5678, lat, mis);
        modelStore(SH, 32'd8, 32'h5678);
        checks++; if (lastWrData !== 32'h12FE5678 || lat !== 3) begin errors++; $display("FAIL sh_merge: data %h lat %0d want 12fe5678 3", lastWrData, lat); end
        doReq(LW, 32'd8, 32'h0, lat, mis);
        refLoad = 32'h12FE5678;
        checks++; if (LoadData !== 32'h12FE5678) begin errors++; $display("FAIL rmw_readback: got %h want 12fe5678", LoadData); end
    endtask

    task automatic test_misaligned();
        int lat; logic mis; int w0; int r0;
        w0 = writeCount; r0 = readCount;
        doReq(LW, 32'd6, 32'h0, lat, mis);
        checks++; if (lat !== 1 || mis !== 1'b1) begin errors++; $display("FAIL lw_misaligned: lat %0d mis %b want 1 1", lat, mis); end
        checks++; if (LoadData !== refLoad) begin errors++; $display("FAIL lw_mis_loaddata: got %h want %h", LoadData, refLoad); end
        doReq(SH, 32'd5, 32'hFFFF, lat, mis);
        checks++; if (lat !== 1 || mis !== 1'b1) begin errors++; $display("FAIL sh_misaligned: lat %0d mis %b want 1 1", lat, mis); end
        checks++; if (readCount !== r0 || writeCount !== w0) begin errors++; $display("FAIL mis_no_access: rd %0d wr %0d want 0 0", readCount - r0, writeCount - w0); end
        checks++; if (LoadData !== refLoad) begin errors++; $display("FAIL sh_mis_loaddata: got %h want %h", LoadData, refLoad); end
    endtask

    task automatic test_reset_mid();
        int lat; logic mis; int w0; int doneSeen;
        poke(3, 32'h0A1B2C3D);
        w0 = writeCount;
        @(negedge Clk);
        Req = 1'b1; Op = SB; Addr = 32'd12; StoreData = 32'h77;
        @(negedge Clk);
        Req = 1'b0;
        checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL rmw_rd_read: got %b want 1", MemRead); end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        refLoad = 32'h0;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || Misaligned !== 1'b0 || MemRead !== 1'b0 || MemWrite !== 1'b0) begin
            errors++; $display("FAIL midreset_ctrl: busy %b done %b mis %b rd %b wr %b want all 0", Busy, Done, Misaligned, MemRead, MemWrite);
        end
        checks++; if (LoadData !== 32'h0 || MemAddress !== 32'h0 || MemWriteData !== 32'h0) begin
            errors++; $display("FAIL midreset_data: load %h addr %h wdata %h want 0 0 0", LoadData, MemAddress, MemWriteData);
        end
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (Done === 1'b1) doneSeen++;
        end
        checks++; if (doneSeen !== 0 || writeCount !== w0) begin errors++; $display("FAIL midreset_quiet: done %0d writes %0d want 0 0", doneSeen, writeCount - w0); end
        doReq(LW, 32'd12, 32'h0, lat, mis);
        refLoad = 32'h0A1B2C3D;
        checks++; if (LoadData !== 32'h0A1B2C3D) begin errors++; $display("FAIL midreset_mem: got %h want 0a1b2c3d", LoadData); end
    endtask

    task automatic test_back_to_back();
        int w0; int n; logic [31:0] a;
        a  = $urandom;
        w0 = writeCount;
        @(negedge Clk);
        Req = 1'b1; Op = SW; Addr = 32'd16; StoreData = a;
        n = 0;
        while (n < 10) begin
            @(negedge Clk);
            n++;
            if (Done === 1'b1) break;
            Addr = $urandom_range(0, 63) * 4;
            StoreData = $urandom;
        end
        modelStore(SW, 32'd16, a);
        checks++; if (n !== 2 || Busy !== 1'b0) begin errors++; $display("FAIL b2b_sw_done: cycles %0d busy %b want 2 0", n, Busy); end
        checks++; if (writeCount - w0 !== 1 || lastWrAddr !== 32'd16 || lastWrData !== a) begin
            errors++; $display("FAIL b2b_single_write: n %0d addr %h data %h want 1 10 %h", writeCount - w0, lastWrAddr, lastWrData, a);
        end
        Op = LW; Addr = 32'd16;
        @(negedge Clk);
        Req = 1'b0;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy %b want 1", Busy); end
        n = 0;
        while (Done !== 1'b1 && n < 10) begin
            @(negedge Clk);
            n++;
        end
        refLoad = a;
        checks++; if (Done !== 1'b1 || LoadData !== a || writeCount - w0 !== 1) begin
            errors++; $display("FAIL b2b_load: done %b data %h writes %0d want 1 %h 1", Done, LoadData, writeCount - w0, a);
        end
    endtask

    task automatic test_random();
        logic [2:0] op; logic [31:0] addr; logic [31:0] data;
        logic expMis; int expLat; int expReads; int expWrites;
        int lat; logic mis; int w0; int r0;
        for (int n = 0; n < 60; n++) begin
            op   = 3'($urandom_range(0, 7));
            addr = $urandom_range(0, 255);
            data = $urandom;
            expMis    = modelMis(op, addr);
            expLat    = expMis ? 1 : ((op == SH || op == SB) ? 3 : 2);
            expReads  = (!expMis && op != SW) ? 1 : 0;
            expWrites = (!expMis && op >= SW) ? 1 : 0;
            w0 = writeCount; r0 = readCount;
            doReq(op, addr, data, lat, mis);
            if (!expMis) begin
                if (op < SW) refLoad = modelLoad(op, addr);
                else modelStore(op, addr, data);
            end
            checks++; if (lat !== expLat || mis !== expMis) begin
                errors++; $display("FAIL rand_%0d_timing op %0d addr %h: lat %0d mis %b want %0d %b", n, op, addr, lat, mis, expLat, expMis);
            end
            checks++; if (LoadData !== refLoad) begin
                errors++; $display("FAIL rand_%0d_load op %0d addr %h: got %h want %h", n, op, addr, LoadData, refLoad);
            end
            checks++; if (readCount - r0 !== expReads || writeCount - w0 !== expWrites) begin
                errors++; $display("FAIL rand_%0d_bus op %0d: rd %0d wr %0d want %0d %0d", n, op, readCount - r0, writeCount - w0, expReads, expWrites);
            end
            if (expWrites == 1) begin
                checks++; if (lastWrAddr !== (addr & ~32'd3) || lastWrData !== refMem[addr[7:2]]) begin
                    errors++; $display("FAIL rand_%0d_write op %0d: addr %h data %h want %h %h", n, op, lastWrAddr, lastWrData, addr & ~32'd3, refMem[addr[7:2]]);
                end
            end
        end
    endtask

    task automatic test_protocol();
        checks++; if (overlapCount !== 0) begin errors++; $display("FAIL enables_overlap: got %0d want 0", overlapCount); end
        checks++; if (strayMisCount !== 0) begin errors++; $display("FAIL misaligned_without_done: got %0d want 0", strayMisCount); end
    endtask

    initial begin
        Reset = 1'b1; Req = 1'b0; Op = 3'd0; Addr = 32'h0; StoreData = 32'h0;
        test_reset();
        test_store_load();
        test_subword_loads();
        test_rmw();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
